// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath width and the multiply
// sequencer state encoding.
package alu_pkg;

   localparam int DATA_W = 16;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_FOR = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADD  = 3'd1,
      ST_SHL  = 3'd2,
      ST_SHR  = 3'd3,
      ST_DONE = 3'd4
   } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response and shared-ALU signals of the multiply sequencer.
// slave = sequencer side, master = pipeline plus ALU side.
interface alu_mul_sequencer_if;
   import alu_pkg::*;

   logic              start;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] alu_src1;
   logic [DATA_W-1:0] alu_src2;
   logic [2:0]        alu_op;
   logic [DATA_W-1:0] alu_out;

   modport master (
      output start, op_a, op_b, alu_out,
      input  busy, done, result, alu_src1, alu_src2, alu_op
   );

   modport slave (
      input  start, op_a, op_b, alu_out,
      output busy, done, result, alu_src1, alu_src2, alu_op
   );

endinterface

// File: rtl/alu_mul_counter.sv
// 5-bit shift-add iteration counter; tc flags that the current increment
// completes the last of ITER iterations.
module alu_mul_counter #(
   parameter int ITER = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [4:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (inc) begin
         cnt_reg <= cnt_reg + 5'd1;
      end
   end

   assign tc = ((cnt_reg + 5'd1) == 5'(ITER));

endmodule

// File: rtl/alu_mul_sequencer.sv
// 16x16 (low half) multiplier that time-shares the execute-stage ALU via ADD/SLL/SRL.
// Optional macro ALU_MUL_EARLY_EXIT_EN stops once the remaining multiplier is zero.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int ITER = 16
) (
   input logic                clk,
   input logic                rst_n,
   alu_mul_sequencer_if.slave bus
);

   mul_state_t        state_reg, state_next;
   logic [DATA_W-1:0] acc_reg, acc_next;
   logic [DATA_W-1:0] a_reg, a_next;
   logic [DATA_W-1:0] b_reg, b_next;
   logic [DATA_W-1:0] result_reg, result_next;
   logic              cnt_clr, cnt_inc, cnt_tc, last_iter;
   logic [2:0]        alu_op;
   logic [DATA_W-1:0] alu_src1, alu_src2;

   alu_mul_counter #(.ITER(ITER)) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .tc    (cnt_tc)
   );

`ifdef ALU_MUL_EARLY_EXIT_EN
   // In SHR alu_out is the shifted multiplier: zero means no partial products remain.
   assign last_iter = cnt_tc || (bus.alu_out == '0);
`else
   assign last_iter = cnt_tc;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         acc_reg    <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         result_reg <= result_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      acc_next    = acc_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      result_next = result_reg;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      alu_op      = ALU_AND;
      alu_src1    = '0;
      alu_src2    = '0;

      unique case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               a_next     = bus.op_a;
               b_next     = bus.op_b;
               acc_next   = '0;
               cnt_clr    = 1'b1;
               state_next = ST_ADD;
            end
         end
         ST_ADD: begin
            alu_op   = ALU_ADD;
            alu_src1 = acc_reg;
            alu_src2 = a_reg;
            if (b_reg[0]) acc_next = bus.alu_out;
            state_next = ST_SHL;
         end
         ST_SHL: begin
            alu_op     = ALU_SLL;
            alu_src1   = a_reg;
            alu_src2   = DATA_W'(1);
            a_next     = bus.alu_out;
            state_next = ST_SHR;
         end
         ST_SHR: begin
            alu_op   = ALU_SRL;
            alu_src1 = b_reg;
            alu_src2 = DATA_W'(1);
            b_next   = bus.alu_out;
            cnt_inc  = 1'b1;
            if (last_iter) begin
               // acc is final here; capture so result is valid alongside done.
               result_next = acc_reg;
               state_next  = ST_DONE;
            end else begin
               state_next  = ST_ADD;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.busy     = (state_reg != ST_IDLE);
   assign bus.done     = (state_reg == ST_DONE);
   assign bus.result   = result_reg;
   assign bus.alu_op   = alu_op;
   assign bus.alu_src1 = alu_src1;
   assign bus.alu_src2 = alu_src2;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU, vector table, random products
// and hand-written sequences for repeated start, mid-run reset and ALU drive.
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   localparam int ITER    = 16;
   localparam int MAX_CYC = 200;

   logic clk;
   logic rst_n;
   int   checks;
   int   passes;

   alu_mul_sequencer_if bus ();

   alu_mul_sequencer #(.ITER(ITER)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared execute-stage ALU, combinational.
   always_comb begin
      bus.alu_out = '0;
      case (bus.alu_op)
         ALU_AND: bus.alu_out = bus.alu_src1 & bus.alu_src2;
         ALU_ADD: bus.alu_out = bus.alu_src1 + bus.alu_src2;
         ALU_SUB: bus.alu_out = bus.alu_src1 - bus.alu_src2;
         ALU_SLL: bus.alu_out = bus.alu_src1 << bus.alu_src2;
         ALU_SRL: bus.alu_out = bus.alu_src1 >> bus.alu_src2;
         ALU_FOR: bus.alu_out = bus.alu_src2;
         default: bus.alu_out = '0;
      endcase
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_res;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   function automatic logic [15:0] model_product(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      p = a * b;
      return p[15:0];
   endfunction

   // Cycle (after the accept edge) in which done is expected.
   function automatic int model_latency(input logic [15:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
      int steps;
      steps = 1;
      for (int i = 0; i < 16; i++) if (b[i]) steps = i + 1;
      if (steps > ITER) steps = ITER;
      return 3 * steps + 1;
`else
      return 3 * ITER + 1;
`endif
   endfunction

   task automatic accept(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic run_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res);
      int lat;
      lat = 0;
      accept(a, b);
      for (int c = 1; c <= MAX_CYC; c++) begin
         @(negedge clk);
         if (c == 1) chk($sformatf("%s busy", name), 32'(bus.busy), 32'd1);
         if (bus.done) begin
            lat = c;
            break;
         end
      end
      chk($sformatf("%s latency", name), 32'(lat), 32'(model_latency(b)));
      chk($sformatf("%s result", name), 32'(bus.result), 32'(exp_res));
      $display("mul %s: a=0x%04h b=0x%04h result=0x%04h done_cycle=%0d", name, a, b, bus.result, lat);
      @(negedge clk);
      chk($sformatf("%s done_pulse", name), {30'd0, bus.done, bus.busy}, 32'd0);
      chk($sformatf("%s hold", name), 32'(bus.result), 32'(exp_res));
   endtask

   initial begin
      logic [15:0] ra, rb;
      int          exp_lat;
      int          lat;
      checks    = 0;
      passes    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;

      vecs[0] = '{16'd7,    16'd6,    16'h002A};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001};
      vecs[2] = '{16'h0100, 16'h0100, 16'h0000};
      vecs[3] = '{16'd1234, 16'd0,    16'h0000};
      vecs[4] = '{16'd3,    16'd5,    16'd15};
      vecs[5] = '{16'h8001, 16'h8000, 16'h8000};
      vecs[6] = '{16'd2,    16'd3,    16'd6};

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset result", 32'(bus.result), 32'd0);
      chk("reset alu_op", 32'(bus.alu_op), 32'(ALU_AND));
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_res);
      end

      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 2 == 1) rb = rb >> $urandom_range(0, 15);
         run_mul($sformatf("rand%0d", i), ra, rb, model_product(ra, rb));
      end

      // Repeated start while busy (and during DONE) must be ignored.
      accept(16'd3, 16'd5);
      exp_lat = model_latency(16'd5);
      lat = 0;
      for (int c = 1; c <= MAX_CYC; c++) begin
         @(negedge clk);
         bus.start = (c >= 2);
         bus.op_a  = 16'd9;
         bus.op_b  = 16'd9;
         if (bus.done) begin
            lat = c;
            break;
         end
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk("restart latency", 32'(lat), 32'(exp_lat));
      @(negedge clk);
      chk("restart idle", 32'(bus.busy), 32'd0);
      chk("restart result", 32'(bus.result), 32'd15);
      $display("mul restart: result=0x%04h done_cycle=%0d", bus.result, lat);
      repeat (3) @(negedge clk);
      chk("restart hold", 32'(bus.result), 32'd15);

      // Asynchronous reset mid-operation.
      accept(16'd7, 16'd6);
      repeat (5) @(negedge clk);
      chk("midrst busy before", 32'(bus.busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst done", 32'(bus.done), 32'd0);
      chk("midrst result", 32'(bus.result), 32'd0);
      $display("reset mid-run: busy=%0b done=%0b result=0x%04h", bus.busy, bus.done, bus.result);
      @(negedge clk);
      rst_n = 1'b1;
      run_mul("post_reset", 16'd2, 16'd3, 16'd6);

      // ALU drive pattern during a 5x3 multiply.
      @(negedge clk);
      chk("idle alu_op", 32'(bus.alu_op), 32'(ALU_AND));
      chk("idle alu_src", {bus.alu_src1, bus.alu_src2}, 32'd0);
      accept(16'd5, 16'd3);
      exp_lat = model_latency(16'd3);
      for (int c = 1; c <= exp_lat; c++) begin
         @(negedge clk);
         if (c < exp_lat) begin
            case ((c - 1) % 3)
               0: chk($sformatf("alu c%0d op", c), 32'(bus.alu_op), 32'(ALU_ADD));
               1: begin
                  chk($sformatf("alu c%0d op", c), 32'(bus.alu_op), 32'(ALU_SLL));
                  chk($sformatf("alu c%0d src2", c), 32'(bus.alu_src2), 32'd1);
               end
               default: begin
                  chk($sformatf("alu c%0d op", c), 32'(bus.alu_op), 32'(ALU_SRL));
                  chk($sformatf("alu c%0d src2", c), 32'(bus.alu_src2), 32'd1);
                  chk($sformatf("alu c%0d src1", c), 32'(bus.alu_src1), 32'(16'd3 >> ((c - 1) / 3)));
               end
            endcase
         end else begin
            chk("alu done flag", 32'(bus.done), 32'd1);
            chk("alu done op", 32'(bus.alu_op), 32'(ALU_AND));
            chk("alu done src", {bus.alu_src1, bus.alu_src2}, 32'd0);
            chk("alu result", 32'(bus.result), 32'd15);
         end
      end
      $display("alu monitor 5x3: result=0x%04h", bus.result);
      @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
